// File: rtl/sdram_wr_burst_ctrl.sv
// Pixel write path into SDRAM: buffers generator words in a FWFT FIFO and
// issues fixed-length, linearly addressed burst write requests per frame.
module sdram_wr_burst_ctrl #(
  parameter int DATA_DEPTH = 1024*768,
  parameter int BURST_LEN  = 256,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              wr_en_o,
  input  logic              data_en_i,
  input  logic [15:0]       din,
  output logic              sdram_wr_req_o,
  input  logic              sdram_wr_ack_i,
  output logic [ADDR_W-1:0] sdram_wr_addr_o,
  output logic [8:0]        sdram_wr_len_o,
  input  logic              sdram_wr_pop_i,
  output logic [15:0]       sdram_wr_data_o,
  output logic              frame_done_o,
  output logic              err_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int WL_W  = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, WAIT_DATA, REQ, XFER, DONE} state_t;
  state_t state, state_nxt;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [LVL_W-1:0] level;
  logic             full, empty, push, pop, xfer_pop;
  logic [WL_W-1:0]  words_left;
  logic [ADDR_W-1:0] addr;
  logic [8:0]       burst_left, cur_len;

  assign full     = level == LVL_W'(FIFO_DEPTH);
  assign empty    = level == '0;
  assign push     = data_en_i & ~full;
  assign pop      = sdram_wr_pop_i & ~empty;
  assign xfer_pop = pop & (state == XFER);
  assign cur_len  = (words_left >= WL_W'(BURST_LEN)) ? 9'(BURST_LEN) : words_left[8:0];
  // Empty FIFO presents zero so the data port reads 0 out of reset.
  assign sdram_wr_data_o = empty ? 16'h0 : mem[rptr];

  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      err_o   <= 1'b0;
      wr_en_o <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // Pops outside XFER still drain the FIFO but are flagged.
      if ((data_en_i & full) | (sdram_wr_pop_i & empty) | (sdram_wr_pop_i & (state != XFER)))
        err_o <= 1'b1;
      // Four-entry margin absorbs the registered ready plus the generator's registered data_en.
      wr_en_o <= (state != IDLE) && (level <= LVL_W'(FIFO_DEPTH - 4));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start_i) state_nxt = WAIT_DATA;
      WAIT_DATA: if (level >= LVL_W'(cur_len)) state_nxt = REQ;
      REQ:       if (sdram_wr_ack_i) state_nxt = XFER;
      XFER:      if (xfer_pop && burst_left == 9'd1)
                   state_nxt = (words_left == WL_W'(1)) ? DONE : WAIT_DATA;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sdram_wr_req_o = (state == REQ);
    frame_done_o   = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_left      <= '0;
      addr            <= '0;
      burst_left      <= '0;
      sdram_wr_addr_o <= '0;
      sdram_wr_len_o  <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        words_left <= WL_W'(DATA_DEPTH);
        addr       <= '0;
      end
      if (state == WAIT_DATA && state_nxt == REQ) begin
        sdram_wr_len_o  <= cur_len;
        sdram_wr_addr_o <= addr;
      end
      if (state == REQ && sdram_wr_ack_i) begin
        burst_left <= sdram_wr_len_o;
        addr       <= addr + ADDR_W'(sdram_wr_len_o);
      end
      if (xfer_pop) begin
        burst_left <= burst_left - 9'd1;
        words_left <= words_left - WL_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Randomized bench for sdram_wr_burst_ctrl: queue-based FIFO model plus
// arithmetic burst expectations, with a bench-side generator and SDRAM controller.
module tb_sdram_wr_burst_ctrl;
  localparam int DD = 1000, BL = 256, FD = 512, AW = 20;

  logic clk = 1'b0;
  logic rst, start_i, wr_en_o, data_en_i, sdram_wr_req_o, sdram_wr_ack_i;
  logic sdram_wr_pop_i, frame_done_o, err_o;
  logic [15:0] din, sdram_wr_data_o;
  logic [AW-1:0] sdram_wr_addr_o;
  logic [8:0] sdram_wr_len_o;

  always #5 clk = ~clk;

  sdram_wr_burst_ctrl #(.DATA_DEPTH(DD), .BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .wr_en_o(wr_en_o), .data_en_i(data_en_i),
    .din(din), .sdram_wr_req_o(sdram_wr_req_o), .sdram_wr_ack_i(sdram_wr_ack_i),
    .sdram_wr_addr_o(sdram_wr_addr_o), .sdram_wr_len_o(sdram_wr_len_o),
    .sdram_wr_pop_i(sdram_wr_pop_i), .sdram_wr_data_o(sdram_wr_data_o),
    .frame_done_o(frame_done_o), .err_o(err_o));

  int n_chk, n_fail;
  logic [15:0] q[$];
  bit m_err, m_active, m_done, m_xfer, wr_exp;
  int m_frame_rem, m_burst_rem, m_bidx;
  int cs, cnt, ack_dly, pop_pct, gen_pct, gen_left, bursts;
  bit force_de, wr_prev, mid_start, start_req;
  logic [15:0] gen_val;
  logic [AW-1:0] hold_addr;
  logic [8:0] hold_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_len();
    return (m_frame_rem < BL) ? m_frame_rem : BL;
  endfunction

  function automatic int exp_addr();
    return (m_bidx * BL) % (1 << AW);
  endfunction

  // Bench-side SDRAM controller and generator decisions for the coming cycle.
  task automatic decide();
    sdram_wr_ack_i = 1'b0;
    sdram_wr_pop_i = 1'b0;
    start_i        = 1'b0;
    if (start_req) begin start_i = 1'b1; start_req = 1'b0; end
    if (cs == 2 && !m_xfer) cs = 0;
    if (cs == 0 && sdram_wr_req_o) begin
      chk("req_active", 32'(m_active), 32'd1);
      chk("req_addr", 32'(sdram_wr_addr_o), 32'(exp_addr()));
      chk("req_len", 32'(sdram_wr_len_o), 32'(exp_len()));
      chk("req_level", 32'(q.size() >= exp_len()), 32'd1);
      hold_addr = 20'(exp_addr());
      hold_len  = 9'(exp_len());
      cnt = ack_dly; cs = 1; bursts++;
    end else if (cs == 1) begin
      chk("req_hold", 32'(sdram_wr_req_o), 32'd1);
      chk("addr_hold", 32'(sdram_wr_addr_o), 32'(hold_addr));
      chk("len_hold", 32'(sdram_wr_len_o), 32'(hold_len));
    end
    if (cs == 1) begin
      if (cnt == 0) begin sdram_wr_ack_i = 1'b1; cs = 2; end
      else cnt--;
    end else if (cs == 2) begin
      chk("req_low_xfer", 32'(sdram_wr_req_o), 32'd0);
      if (q.size() > 0 && $urandom_range(99) < pop_pct) sdram_wr_pop_i = 1'b1;
      if (mid_start) begin start_i = 1'b1; mid_start = 1'b0; end
    end
    data_en_i = force_de || (wr_prev && gen_left > 0 && $urandom_range(99) < gen_pct);
    din = gen_val;
    wr_prev = wr_en_o;
  endtask

  // One clock: advance the reference model and check per-cycle outputs.
  task automatic tick();
    bit pre_active, done_was, req_pre;
    int pre_lvl;
    pre_active = m_active;
    pre_lvl    = q.size();
    req_pre    = sdram_wr_req_o;
    if (sdram_wr_pop_i && pre_lvl > 0) chk("pop_data", 32'(sdram_wr_data_o), 32'(q[0]));
    @(posedge clk);
    wr_exp = pre_active && (pre_lvl <= FD - 4);
    if (data_en_i && pre_lvl == FD) m_err = 1'b1;
    if (sdram_wr_pop_i && (pre_lvl == 0 || !m_xfer)) m_err = 1'b1;
    done_was = m_done;
    m_done = 1'b0;
    if (sdram_wr_pop_i && pre_lvl > 0) begin
      void'(q.pop_front());
      if (m_xfer) begin
        m_burst_rem--; m_frame_rem--;
        if (m_burst_rem == 0) begin
          m_xfer = 1'b0;
          if (m_frame_rem == 0) m_done = 1'b1;
        end
      end
    end
    if (data_en_i && pre_lvl < FD) q.push_back(din);
    if (data_en_i) begin gen_val++; if (gen_left > 0) gen_left--; end
    if (sdram_wr_ack_i && req_pre) begin
      m_xfer = 1'b1; m_burst_rem = exp_len(); m_bidx++;
    end
    if (done_was) m_active = 1'b0;
    if (!pre_active && start_i) begin
      m_active = 1'b1; m_frame_rem = DD; m_bidx = 0;
    end
    @(negedge clk);
    chk("wr_en", 32'(wr_en_o), 32'(wr_exp));
    chk("err", 32'(err_o), 32'(m_err));
    chk("frame_done", 32'(frame_done_o), 32'(m_done));
  endtask

  // mode 0: until frame_done, 1: fixed cycle count, 2: until 100 words left in burst
  task automatic run(input int mode, input int budget);
    int n;
    bit stop;
    n = 0; stop = 1'b0;
    while (!stop && n < budget) begin
      decide();
      tick();
      n++;
      if (mode == 0 && frame_done_o) stop = 1'b1;
      if (mode == 2 && m_xfer && m_burst_rem == 100) stop = 1'b1;
    end
    if (mode != 1) begin
      n_chk++;
      assert (stop) else begin
        n_fail++;
        $error("FAIL timeout mode %0d: observed %0d cycles, required stop before %0d", mode, n, budget);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start_i = 1'b0; data_en_i = 1'b0; din = '0;
    sdram_wr_ack_i = 1'b0; sdram_wr_pop_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_err = 0; m_active = 0; m_done = 0; m_xfer = 0; wr_exp = 0;
    cs = 0; wr_prev = 0; mid_start = 0; force_de = 0; start_req = 0;
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_req", 32'(sdram_wr_req_o), 32'd0);
    chk("rst_addr", 32'(sdram_wr_addr_o), 32'd0);
    chk("rst_len", 32'(sdram_wr_len_o), 32'd0);
    chk("rst_data", 32'(sdram_wr_data_o), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
  endtask

  task automatic frame(input int adly, input int ppct, input int gpct, input int words, input bit mid);
    ack_dly = adly; pop_pct = ppct; gen_pct = gpct; gen_left = words;
    bursts = 0; mid_start = mid; start_req = 1'b1;
    run(0, 20000);
    chk("burst_count", 32'(bursts), 32'd4);
    chk("frame_err", 32'(err_o), 32'd0);
    run(1, 3);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; gen_val = '0; gen_left = 0; force_de = 0;
    do_reset();
    run(1, 5);

    // Stream 0..999, ack after 3 cycles, continuous pops.
    frame(3, 100, 100, DD, 1'b0);
    // Long ack wait, bursty pops, surplus words and a start pulse mid-transfer.
    frame(50, 60, 80, DD + 20, 1'b1);

    // Controller stalls after first ack: FIFO fills and ready must drop.
    ack_dly = 2; pop_pct = 0; gen_pct = 100; gen_left = 2000;
    bursts = 0; start_req = 1'b1;
    run(1, 700);
    chk("wr_en_low_when_full", 32'(wr_en_o), 32'd0);
    force_de = 1'b1;
    run(1, FD - q.size() + 3);
    force_de = 1'b0;
    chk("err_after_overflow", 32'(err_o), 32'd1);
    run(1, 5);
    chk("err_sticky", 32'(err_o), 32'd1);

    // Drain part of the burst, then reset with 100 words left in it.
    pop_pct = 100; gen_left = 0;
    run(2, 400);
    do_reset();
    run(1, 3);
    frame($urandom_range(0, 5), 100, 50, DD, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
